mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one unified byte-addressed memory between the instruction-fetch port and the load/store port of the core. It accepts at most one request per cycle, grants data over fetch with a starvation guard, drives the memory from a registered issue stage and returns registered read data two cycles after grant. It sits between the fetch/LSU logic and the memory unit, whose read path is combinational and whose write commits on the clock edge.

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arb_prio.sv | 44 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and helpers for the fetch/load-store memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    WIDTH_B = 2'b00,
    WIDTH_H = 2'b01,
    WIDTH_W = 2'b10,
    WIDTH_X = 2'b11
  } width_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_MAX       = 15;

  // Fetches are always full words; width 11 is never legal.
  function automatic logic misaligned(input logic is_fetch, input width_e width,
                                      input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (is_fetch) begin
      bad = (lsb != 2'b00);
    end else begin
      unique case (width)
        WIDTH_B: bad = 1'b0;
        WIDTH_H: bad = lsb[0];
        WIDTH_W: bad = (lsb != 2'b00);
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped in one bundle.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_write;
  logic [1:0]        d_width;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_width;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_write, d_width, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_wdata, mem_width, mem_write
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_write, d_width, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_addr, mem_wdata, mem_width, mem_write
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Grant selection: data wins by default, a fetch that has lost STARVE_LIMIT
// consecutive cycles wins once.
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  logic [3:0] starve_q, starve_d;
  logic       starved;

  assign starved = (starve_q >= 4'(STARVE_LIMIT));

  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    if (!rst) begin
      if_gnt_o = if_req_i & (~d_req_i | starved);
      d_gnt_o  = d_req_i & ~if_gnt_o;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o) begin
      starve_d = '0;
    end else if (starve_q != 4'(STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: grant in N, memory access in N+1, response in N+2.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int          ADDR_W       = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  logic if_gnt, d_gnt;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .if_gnt_o (if_gnt),
    .d_gnt_o  (d_gnt)
  );

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // Stage p1: issue register, drives the memory
  logic              vld_p1_q,   vld_p1_d;
  owner_e            own_p1_q,   own_p1_d;
  logic [ADDR_W-1:0] addr_p1_q,  addr_p1_d;
  logic [31:0]       wdata_p1_q, wdata_p1_d;
  width_e            width_p1_q, width_p1_d;
  logic              write_p1_q, write_p1_d;
  logic              err_p1_q,   err_p1_d;

  always_comb begin
    vld_p1_d   = 1'b0;
    own_p1_d   = own_p1_q;
    addr_p1_d  = addr_p1_q;
    wdata_p1_d = wdata_p1_q;
    width_p1_d = width_p1_q;
    write_p1_d = write_p1_q;
    err_p1_d   = err_p1_q;
    if (if_gnt) begin
      vld_p1_d   = 1'b1;
      own_p1_d   = OWN_IF;
      addr_p1_d  = bus.if_addr;
      width_p1_d = WIDTH_W;
      write_p1_d = 1'b0;
      err_p1_d   = misaligned(1'b1, WIDTH_W, bus.if_addr[1:0]);
    end else if (d_gnt) begin
      vld_p1_d   = 1'b1;
      own_p1_d   = OWN_D;
      addr_p1_d  = bus.d_addr;
      wdata_p1_d = bus.d_wdata;
      width_p1_d = width_e'(bus.d_width);
      write_p1_d = bus.d_write;
      err_p1_d   = misaligned(1'b0, width_e'(bus.d_width), bus.d_addr[1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      own_p1_q   <= OWN_IF;
      addr_p1_q  <= '0;
      wdata_p1_q <= '0;
      width_p1_q <= WIDTH_B;
      write_p1_q <= 1'b0;
      err_p1_q   <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      own_p1_q   <= own_p1_d;
      addr_p1_q  <= addr_p1_d;
      wdata_p1_q <= wdata_p1_d;
      width_p1_q <= width_p1_d;
      write_p1_q <= write_p1_d;
      err_p1_q   <= err_p1_d;
    end
  end

  assign bus.mem_addr  = addr_p1_q;
  assign bus.mem_wdata = wdata_p1_q;
  assign bus.mem_width = width_p1_q;
  // A store sitting in the issue stage while rst is high must not commit.
  assign bus.mem_write = vld_p1_q & (own_p1_q == OWN_D) & write_p1_q & ~err_p1_q & ~rst;

  // Stage p2: response register
  logic        vld_p2_q,   vld_p2_d;
  owner_e      own_p2_q,   own_p2_d;
  logic [31:0] rdata_p2_q, rdata_p2_d;
  logic        err_p2_q,   err_p2_d;

  always_comb begin
    vld_p2_d   = vld_p1_q;
    own_p2_d   = own_p2_q;
    rdata_p2_d = rdata_p2_q;
    err_p2_d   = err_p2_q;
    if (vld_p1_q) begin
      own_p2_d   = own_p1_q;
      err_p2_d   = err_p1_q;
      rdata_p2_d = (write_p1_q || err_p1_q) ? 32'd0 : bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      own_p2_q   <= OWN_IF;
      rdata_p2_q <= '0;
      err_p2_q   <= 1'b0;
    end else begin
      vld_p2_q   <= vld_p2_d;
      own_p2_q   <= own_p2_d;
      rdata_p2_q <= rdata_p2_d;
      err_p2_q   <= err_p2_d;
    end
  end

  assign bus.if_rvalid = vld_p2_q & (own_p2_q == OWN_IF);
  assign bus.d_rvalid  = vld_p2_q & (own_p2_q == OWN_D);
  assign bus.if_rdata  = rdata_p2_q;
  assign bus.d_rdata   = rdata_p2_q;
  assign bus.if_err    = bus.if_rvalid & err_p2_q;
  assign bus.d_err     = bus.d_rvalid & err_p2_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: tasks queue hand-computed responses, monitors pop and compare.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) bus_if ();

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    int          cyc;
  } iss_t;

  rsp_t sb_q[$];
  iss_t iss_q[$];
  rsp_t mon_e;
  iss_t iss_e;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wcount = 0;
  bit mon_en = 1'b0;
  logic [31:0] mem [0:63];

  // Memory model: combinational read of the aligned word, byte-lane write at the clock edge.
  assign bus_if.mem_rdata = mem[bus_if.mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_if.mem_write === 1'b1) begin
      wcount <= wcount + 1;
      case (bus_if.mem_width)
        2'b00:   mem[bus_if.mem_addr[7:2]][bus_if.mem_addr[1:0]*8 +: 8] <= bus_if.mem_wdata[7:0];
        2'b01:   mem[bus_if.mem_addr[7:2]][bus_if.mem_addr[1]*16 +: 16] <= bus_if.mem_wdata[15:0];
        default: mem[bus_if.mem_addr[7:2]] <= bus_if.mem_wdata;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (mon_en && (bus_if.if_rvalid || bus_if.d_rvalid)) begin
      check("dual_rvalid", {31'd0, bus_if.if_rvalid & bus_if.d_rvalid}, 32'd0);
      check("rsp_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("rsp_owner", {31'd0, bus_if.if_rvalid}, {31'd0, mon_e.is_if});
        check("rsp_latency", cyc, mon_e.cyc);
        check("rsp_rdata", mon_e.is_if ? bus_if.if_rdata : bus_if.d_rdata, mon_e.rdata);
        check("rsp_err", {31'd0, mon_e.is_if ? bus_if.if_err : bus_if.d_err}, {31'd0, mon_e.err});
      end
    end
  end

  // Issue monitor
  always @(negedge clk) begin
    if (mon_en) begin
      check("dual_gnt", {31'd0, bus_if.if_gnt & bus_if.d_gnt}, 32'd0);
      if (iss_q.size() != 0 && iss_q[0].cyc == cyc) begin
        iss_e = iss_q.pop_front();
        check("mem_addr", bus_if.mem_addr, iss_e.addr);
        check("mem_write", {31'd0, bus_if.mem_write}, {31'd0, iss_e.wr & !rst});
      end else begin
        check("idle_mem_write", {31'd0, bus_if.mem_write}, 32'd0);
      end
    end
  end

  task automatic push_exp(input bit is_if, input logic [31:0] addr, input bit wr,
                          input logic [31:0] rdata, input bit err, input bit want_rsp);
    rsp_t r;
    iss_t s;
    s.addr = addr; s.wr = wr && !err; s.cyc = cyc + 1;
    iss_q.push_back(s);
    if (want_rsp) begin
      r.is_if = is_if; r.rdata = rdata; r.err = err; r.cyc = cyc + 2;
      sb_q.push_back(r);
    end
  endtask

  // Called just after a posedge; returns just after the posedge following the grant.
  task automatic issue_d(input logic [31:0] addr, input bit wr, input logic [1:0] wd,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err, input bit want_rsp);
    bit got;
    got = 1'b0;
    bus_if.d_req = 1'b1; bus_if.d_addr = addr; bus_if.d_write = wr;
    bus_if.d_width = wd; bus_if.d_wdata = wdata;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus_if.d_gnt) begin
        push_exp(1'b0, addr, wr, exp_rdata, exp_err, want_rsp);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus_if.d_req = 1'b0;
    check("d_gnt_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic issue_if(input logic [31:0] addr, input logic [31:0] exp_rdata, input bit exp_err);
    bit got;
    got = 1'b0;
    bus_if.if_req = 1'b1; bus_if.if_addr = addr;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus_if.if_gnt) begin
        push_exp(1'b1, addr, 1'b0, exp_rdata, exp_err, 1'b1);
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus_if.if_req = 1'b0;
    check("if_gnt_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wc0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    mem[0]  <= 32'h0000_0013;
    mem[1]  <= 32'h0050_0093;
    mem[4]  <= 32'hDEAD_BEEF;
    mem[12] <= 32'h0BAD_F00D;
    rst = 1'b1;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h0;
    bus_if.d_req = 1'b1;  bus_if.d_addr = 32'h10; bus_if.d_write = 1'b0;
    bus_if.d_width = 2'b10; bus_if.d_wdata = 32'h0;

    @(negedge clk);
    check("rst_if_gnt", {31'd0, bus_if.if_gnt}, 32'd0);
    check("rst_d_gnt", {31'd0, bus_if.d_gnt}, 32'd0);
    bus_if.if_req = 1'b0; bus_if.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mem_addr", bus_if.mem_addr, 32'd0);
    check("rst_mem_width", {30'd0, bus_if.mem_width}, 32'd0);
    check("rst_mem_write", {31'd0, bus_if.mem_write}, 32'd0);
    check("rst_d_rvalid", {31'd0, bus_if.d_rvalid}, 32'd0);
    check("rst_d_rdata", bus_if.d_rdata, 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue_d(32'h10, 1'b0, 2'b10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue_if(32'h04, 32'h0050_0093, 1'b0);
    @(posedge clk); #1;

    // Both requesters held for 12 cycles: fetch must win every 5th cycle.
    bus_if.d_req = 1'b1; bus_if.d_addr = 32'h10; bus_if.d_write = 1'b0; bus_if.d_width = 2'b10;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("starve_if_gnt", {31'd0, bus_if.if_gnt}, {31'd0, (i % 5) == 4});
      check("starve_d_gnt", {31'd0, bus_if.d_gnt}, {31'd0, (i % 5) != 4});
      if (bus_if.if_gnt) push_exp(1'b1, 32'h0, 1'b0, 32'h0000_0013, 1'b0, 1'b1);
      if (bus_if.d_gnt)  push_exp(1'b0, 32'h10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    bus_if.d_req = 1'b0; bus_if.if_req = 1'b0;
    @(posedge clk); #1;

    issue_d(32'h20, 1'b1, 2'b10, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
    issue_d(32'h20, 1'b0, 2'b10, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
    @(posedge clk); #1;

    wc0 = wcount;
    issue_d(32'h21, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue_d(32'h24, 1'b0, 2'b11, 32'h0, 32'h0, 1'b1, 1'b1);
    issue_if(32'h06, 32'h0, 1'b1);
    issue_d(32'h22, 1'b0, 2'b01, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
    issue_d(32'h23, 1'b0, 2'b00, 32'h0, 32'h1122_3344, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("err_no_write", wcount, wc0);
    check("err_mem_intact", mem[8], 32'h1122_3344);

    // Store granted, then reset in the following cycle: nothing may commit or respond.
    issue_d(32'h30, 1'b1, 2'b10, 32'hAAAA_5555, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rstcyc_mem_write", {31'd0, bus_if.mem_write}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_mem_addr", bus_if.mem_addr, 32'd0);
    check("postrst_mem_wdata", bus_if.mem_wdata, 32'd0);
    check("postrst_mem_width", {30'd0, bus_if.mem_width}, 32'd0);
    check("postrst_d_rvalid", {31'd0, bus_if.d_rvalid}, 32'd0);
    check("postrst_d_rdata", bus_if.d_rdata, 32'd0);
    @(posedge clk); #1;
    check("postrst_mem_intact", mem[12], 32'h0BAD_F00D);
    issue_d(32'h20, 1'b0, 2'b10, 32'h0, 32'h1122_3344, 1'b0, 1'b1);

    for (int k = 0; k < 10 && (sb_q.size() != 0 || iss_q.size() != 0); k++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    check("iss_drained", iss_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
